qspi_arb: RTL

Line-transfer arbiter and sequencer for the single QSPI memory controller. It shares the controller between three requesters: instruction-cache fill, data-cache fill/writeback, and an auxiliary loader/DMA port. It replaces the ad-hoc `ifetch ? i : d` muxing in the top level. Only one whole cache line moves at a time; the block counts nibble strobes to detect end of line, then issues a one-cycle `done` to the owner.

---
 rtl/qspi_arb_pkg.sv | 21 ++
 rtl/qspi_arb_if.sv | 69 ++++++
 rtl/qspi_arb_rr_pick3.sv | 31 +++
 rtl/qspi_arb.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI line-transfer arbiter.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NREQ = 3;

  localparam logic [1:0] REQ_I = 2'd0;
  localparam logic [1:0] REQ_D = 2'd1;
  localparam logic [1:0] REQ_X = 2'd2;

  // Successor in the i -> d -> x -> i rotation; an out-of-range index wraps to i.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= REQ_X) ? REQ_I : idx + 2'd1;
  endfunction

endpackage

// File: rtl/qspi_arb_if.sv
// Requester and QSPI-controller signals of the arbiter. The arbiter uses the
// slave view; the caches, the loader and the controller together form the master view.
interface qspi_arb_if #(
  parameter int PA          = 24,
  parameter int LINE_LENGTH = 4
);
  localparam int LB = $clog2(LINE_LENGTH);
  localparam int TW = PA - LB;

  logic          i_req;
  logic [1:0]    i_mem;
  logic [TW-1:0] i_tag;
  logic          i_gnt;
  logic          i_wstrobe;
  logic          i_done;

  logic          d_req;
  logic          d_write;
  logic [1:0]    d_mem;
  logic [TW-1:0] d_tag;
  logic [3:0]    d_dwrite;
  logic          d_gnt;
  logic          d_wstrobe;
  logic          d_rstrobe;
  logic          d_done;

  logic          x_req;
  logic          x_write;
  logic [1:0]    x_mem;
  logic [TW-1:0] x_tag;
  logic [3:0]    x_dwrite;
  logic          x_gnt;
  logic          x_wstrobe;
  logic          x_rstrobe;
  logic          x_done;

  logic          q_req;
  logic          q_i_d;
  logic          q_write;
  logic [1:0]    q_mem;
  logic [TW-1:0] q_paddr;
  logic [3:0]    q_dwrite;
  logic          q_wstrobe_d;
  logic          q_wstrobe_i;
  logic          q_rstrobe_d;

  modport master (
    output i_req, i_mem, i_tag,
    input  i_gnt, i_wstrobe, i_done,
    output d_req, d_write, d_mem, d_tag, d_dwrite,
    input  d_gnt, d_wstrobe, d_rstrobe, d_done,
    output x_req, x_write, x_mem, x_tag, x_dwrite,
    input  x_gnt, x_wstrobe, x_rstrobe, x_done,
    input  q_req, q_i_d, q_write, q_mem, q_paddr, q_dwrite,
    output q_wstrobe_d, q_wstrobe_i, q_rstrobe_d
  );

  modport slave (
    input  i_req, i_mem, i_tag,
    output i_gnt, i_wstrobe, i_done,
    input  d_req, d_write, d_mem, d_tag, d_dwrite,
    output d_gnt, d_wstrobe, d_rstrobe, d_done,
    input  x_req, x_write, x_mem, x_tag, x_dwrite,
    output x_gnt, x_wstrobe, x_rstrobe, x_done,
    output q_req, q_i_d, q_write, q_mem, q_paddr, q_dwrite,
    input  q_wstrobe_d, q_wstrobe_i, q_rstrobe_d
  );

endinterface

// File: rtl/qspi_arb_rr_pick3.sv
// Combinational 3-way round-robin picker: searches upward starting just after
// the most recently granted index.
module rr_pick3
  import qspi_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx
);

  logic [1:0] cand;
  logic       found;

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt   = '0;
    idx   = REQ_I;
    found = 1'b0;
    cand  = next_idx(last);
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

endmodule

// File: rtl/qspi_arb.sv
// Shares the single QSPI controller among icache, dcache and aux requesters,
// moving one whole line per grant and signalling done after the last nibble.
module qspi_arb
  import qspi_arb_pkg::*;
#(
  parameter int PA          = 24,
  parameter int LINE_LENGTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  qspi_arb_if.slave     bus,
  output logic          busy
);

  localparam int LB   = $clog2(LINE_LENGTH);
  localparam int TW   = PA - LB;
  localparam int NNIB = 2 * LINE_LENGTH;
  localparam int CW   = $clog2(NNIB);
  localparam logic [CW-1:0] CNT_LAST = CW'(NNIB - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic [1:0]      last_q, last_d;
  logic            write_q, write_d;
  logic [1:0]      mem_q, mem_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] req, pick_gnt;
  logic [1:0]      pick_idx;
  logic            run, owner_req, cnt_stb;

  assign req = {bus.x_req, bus.d_req, bus.i_req};

  rr_pick3 u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign run       = (state_q == RUN);
  assign owner_req = |(owner_q & req);
  // Writes advance on consumed nibbles; reads on the strobe matching the owner's bus.
  assign cnt_stb   = write_q          ? bus.q_rstrobe_d :
                     owner_q[REQ_I]   ? bus.q_wstrobe_i : bus.q_wstrobe_d;

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= REQ_X;
      write_q <= 1'b0;
      mem_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      write_q <= write_d;
      mem_q   <= mem_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    write_d = write_q;
    mem_d   = mem_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = RUN;
          owner_d = pick_gnt;
          last_d  = pick_idx;
          cnt_d   = '0;
          case (pick_idx)
            REQ_D: begin
              write_d = bus.d_write;
              mem_d   = bus.d_mem;
              tag_d   = bus.d_tag;
            end
            REQ_X: begin
              write_d = bus.x_write;
              mem_d   = bus.x_mem;
              tag_d   = bus.x_tag;
            end
            default: begin
              write_d = 1'b0;
              mem_d   = bus.i_mem;
              tag_d   = bus.i_tag;
            end
          endcase
        end
      end
      RUN: begin
        if (!owner_req) begin
          state_d = IDLE;
          owner_d = '0;
          cnt_d   = '0;
        end else if (cnt_stb) begin
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = '0;
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.q_dwrite = '0;
    if (owner_q[REQ_D])      bus.q_dwrite = bus.d_dwrite;
    else if (owner_q[REQ_X]) bus.q_dwrite = bus.x_dwrite;
  end

  assign bus.i_gnt     = owner_q[REQ_I];
  assign bus.d_gnt     = owner_q[REQ_D];
  assign bus.x_gnt     = owner_q[REQ_X];

  assign bus.i_wstrobe = run & owner_q[REQ_I] & bus.q_wstrobe_i;
  assign bus.d_wstrobe = run & owner_q[REQ_D] & bus.q_wstrobe_d;
  assign bus.x_wstrobe = run & owner_q[REQ_X] & bus.q_wstrobe_d;
  assign bus.d_rstrobe = run & owner_q[REQ_D] & bus.q_rstrobe_d;
  assign bus.x_rstrobe = run & owner_q[REQ_X] & bus.q_rstrobe_d;

  assign bus.i_done    = (state_q == DONE) & owner_q[REQ_I];
  assign bus.d_done    = (state_q == DONE) & owner_q[REQ_D];
  assign bus.x_done    = (state_q == DONE) & owner_q[REQ_X];

  assign bus.q_req     = run;
  assign bus.q_i_d     = owner_q[REQ_I];
  assign bus.q_write   = write_q;
  assign bus.q_mem     = mem_q;
  assign bus.q_paddr   = tag_q;

  assign busy          = (state_q != IDLE);

endmodule
